// File: rtl/i2c_target.sv
// I2C target: synchronised and glitch-filtered SCL/SDA, START/STOP detection, and a
// byte-level FSM that gives a bus controller read/write access to an 8-bit register space.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = 30
) (
  input  logic       clk_100mhz,
  input  logic       sys_rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       start_pulse,
  output logic       stop_pulse
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t        state;
  logic [1:0]    scl_sync, sda_sync;
  logic [FW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    sr;
  logic [7:0]    byte_in;
  logic [2:0]    bit_cnt;
  logic          rw;
  logic [HW-1:0] hold_cnt;
  logic          hold_arm;
  logic          oe_pend;

  // NOTE: synchronizers and filters reset to 1 (idle bus) so leaving reset never fakes an edge.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_cnt <= '0;
      scl_f   <= 1'b1;
    end else if (scl_sync[1] == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == FW'(FILTER_LEN - 1)) begin
      scl_f   <= scl_sync[1];
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sda_cnt <= '0;
      sda_f   <= 1'b1;
    end else if (sda_sync[1] == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == FW'(FILTER_LEN - 1)) begin
      sda_f   <= sda_sync[1];
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in   = {sr[6:0], sda_f};

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      sda_oe      <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 8'h00;
      reg_wr_en   <= 1'b0;
      busy        <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      rw          <= 1'b0;
      hold_cnt    <= '0;
      hold_arm    <= 1'b0;
      oe_pend     <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      reg_wr_en   <= 1'b0;
      if (reg_wr_en) reg_addr <= reg_addr + 8'd1;

      // Every SDA drive change is deferred HOLD_CYCLES clocks past the filtered SCL fall.
      if (hold_arm) begin
        if (hold_cnt == '0) begin
          sda_oe   <= oe_pend;
          hold_arm <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end

      if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= 3'd0;
        busy        <= 1'b1;
        start_pulse <= 1'b1;
        sda_oe      <= 1'b0;
        hold_arm    <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        busy       <= 1'b0;
        stop_pulse <= 1'b1;
        sda_oe     <= 1'b0;
        hold_arm   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WR_DATA: begin
            sr      <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw    <= byte_in[0];
                  state <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end else if (state == PTR) begin
                reg_addr <= byte_in;
                state    <= PTR_ACK;
              end else begin
                reg_wdata <= byte_in;
                reg_wr_en <= 1'b1;
                state     <= WR_ACK;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WR_ACK: bit_cnt <= 3'd1;
          RD_DATA: begin
            sr      <= {sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              state   <= RD_ACK;
            end
          end
          RD_ACK: begin
            reg_addr <= reg_addr + 8'd1;
            if (sda_f) state <= IDLE;
            else       bit_cnt <= 3'd1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        hold_arm <= 1'b1;
        hold_cnt <= HW'(HOLD_CYCLES - 2);
        oe_pend  <= 1'b0;
        case (state)
          ADDR_ACK, PTR_ACK, WR_ACK: begin
            if (bit_cnt == 3'd0) begin
              oe_pend <= 1'b1;
            end else begin
              bit_cnt <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                state   <= RD_DATA;
                sr      <= reg_rdata;
                oe_pend <= ~reg_rdata[7];
              end else begin
                state <= (state == ADDR_ACK) ? PTR : WR_DATA;
              end
            end
          end
          RD_DATA: oe_pend <= ~sr[7];
          RD_ACK: begin
            if (bit_cnt == 3'd1) begin
              bit_cnt <= 3'd0;
              state   <= RD_DATA;
              sr      <= reg_rdata;
              oe_pend <= ~reg_rdata[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: acts as a ~400 kHz bus controller and checks the target against
// a transaction-level model of the register pointer and the expected write strobes.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 626;  // quarter SCL period in ns

  logic       clk_100mhz = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic       scl_ctl    = 1'b1;
  logic       sda_ctl    = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr_en, busy, start_pulse, stop_pulse;
  wire        sda_line = sda_ctl & ~sda_oe;

  assign reg_rdata = reg_addr ^ 8'hFF;

  always #5 clk_100mhz = ~clk_100mhz;

  i2c_target dut (
    .clk_100mhz (clk_100mhz),
    .sys_rst_n  (sys_rst_n),
    .scl_i      (scl_ctl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int oe_cycles = 0;
  int oe_viol = 0;
  logic mon_en = 1'b1;
  logic oe_prev = 1'b0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  ptr_m = 8'h00;

  always @(negedge clk_100mhz) begin
    if (reg_wr_en) obs_q.push_back({reg_addr, reg_wdata});
    if (start_pulse) start_cnt++;
    if (stop_pulse) stop_cnt++;
    if (sda_oe) oe_cycles++;
    if (mon_en && scl_ctl && (sda_oe != oe_prev)) oe_viol++;
    oe_prev = sda_oe;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---- reference model: transaction rules, not cycle behaviour ----
  task automatic model_write(input logic [7:0] ab, input int n, input logic [2:0][7:0] d);
    if (ab[7:1] == 7'h42 && !ab[0] && n > 0) begin
      ptr_m = d[0];
      for (int k = 1; k < n; k++) begin
        exp_q.push_back({ptr_m, d[k]});
        ptr_m = ptr_m + 8'd1;
      end
    end
  endtask

  task automatic model_read(output logic [7:0] v);
    v = ptr_m ^ 8'hFF;
    ptr_m = ptr_m + 8'd1;
  endtask

  task automatic compare_strobes(input string tag);
    check($sformatf("%s_strobe_count", tag), obs_q.size(), exp_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_strobe%0d", tag, k), obs_q[k], exp_q[k]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---- bus controller ----
  task automatic i2c_start();
    sda_ctl = 1'b1;
    #(Q) scl_ctl = 1'b1;
    #(Q) sda_ctl = 1'b0;
    #(Q) scl_ctl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(Q) sda_ctl = 1'b0;
    #(Q) scl_ctl = 1'b1;
    #(Q) sda_ctl = 1'b1;
    #(Q);
  endtask

  // g: 0 clean, 1 = 20 ns SCL low glitch, 2 = 20 ns SDA glitch, both mid SCL-high
  task automatic bit_xfer(input logic b, input int g, output logic r);
    #(Q) sda_ctl = b;
    #(Q) scl_ctl = 1'b1;
    #(300);
    if (g == 1) scl_ctl = 1'b0;
    else if (g == 2) sda_ctl = ~b;
    #(20);
    scl_ctl = 1'b1;
    sda_ctl = b;
    #(Q - 320) r = sda_line;
    #(Q) scl_ctl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int g, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], g, r);
    bit_xfer(1'b1, 0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 0, r);
      d[i] = r;
    end
    bit_xfer(nack, 0, r);
  endtask

  task automatic do_write(input logic [7:0] ab, input int n, input logic [2:0][7:0] d,
                          input logic glitch, output logic [3:0] acks);
    logic a;
    acks = '0;
    i2c_start();
    write_byte(ab, 0, a);
    acks[0] = a;
    for (int k = 0; k < n; k++) begin
      write_byte(d[k], (glitch && k > 0) ? k : 0, a);
      acks[k+1] = a;
    end
  endtask

  typedef struct {
    logic [7:0]      ab;
    int              n;
    logic [2:0][7:0] d;
    logic            glitch;
    logic [3:0]      exp_acks;
    int              exp_strobes;
    logic [7:0]      exp_addr;
  } wvec_t;

  initial begin
    wvec_t      vecs[4];
    logic [3:0] acks;
    logic [7:0] rb, ev, dbyte;
    logic       a, r;

    vecs[0] = '{8'h84, 3, {8'h5A, 8'hA5, 8'h10}, 1'b0, 4'b1111, 2, 8'h12};
    vecs[1] = '{8'h86, 1, {8'h00, 8'h00, 8'h55}, 1'b0, 4'b0000, 0, 8'h12};
    vecs[2] = '{8'h84, 3, {8'h22, 8'h11, 8'hFF}, 1'b0, 4'b1111, 2, 8'h01};
    vecs[3] = '{8'h84, 3, {8'h3C, 8'hC3, 8'h40}, 1'b1, 4'b1111, 2, 8'h42};

    #100 sys_rst_n = 1'b1;
    #200;
    check("reset_sda_oe", sda_oe, 0);
    check("reset_reg_addr", reg_addr, 0);
    check("reset_reg_wdata", reg_wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_en", reg_wr_en, 0);

    for (int i = 0; i < 4; i++) begin
      start_cnt = 0; stop_cnt = 0; oe_cycles = 0;
      do_write(vecs[i].ab, vecs[i].n, vecs[i].d, vecs[i].glitch, acks);
      check($sformatf("vec%0d_busy_before_stop", i), busy, 1);
      i2c_stop();
      model_write(vecs[i].ab, vecs[i].n, vecs[i].d);
      check($sformatf("vec%0d_acks", i), acks, vecs[i].exp_acks);
      check($sformatf("vec%0d_busy_after_stop", i), busy, 0);
      check($sformatf("vec%0d_reg_addr", i), reg_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_reg_addr_model", i), reg_addr, ptr_m);
      check($sformatf("vec%0d_strobes", i), obs_q.size(), vecs[i].exp_strobes);
      check($sformatf("vec%0d_oe_active", i), oe_cycles != 0, vecs[i].exp_acks[0]);
      check($sformatf("vec%0d_starts", i), start_cnt, 1);
      check($sformatf("vec%0d_stops", i), stop_cnt, 1);
      compare_strobes($sformatf("vec%0d", i));
    end

    // Pointer write, repeated START, read three bytes (ACK, ACK, NACK)
    start_cnt = 0; stop_cnt = 0;
    do_write(8'h84, 1, {8'h00, 8'h00, 8'h20}, 1'b0, acks);
    model_write(8'h84, 1, {8'h00, 8'h00, 8'h20});
    i2c_start();
    write_byte(8'h85, 0, a);
    check("rd_addr_ack", a, 1);
    for (int k = 0; k < 3; k++) begin
      read_byte(k == 2, rb);
      model_read(ev);
      check($sformatf("rd_byte%0d", k), rb, ev);
    end
    check("rd_released_after_nack", sda_oe, 0);
    i2c_stop();
    check("rd_ptr_acks", acks, 4'b0011);
    check("rd_reg_addr", reg_addr, 8'h23);
    check("rd_reg_addr_model", reg_addr, ptr_m);
    check("rd_starts", start_cnt, 2);
    check("rd_stops", stop_cnt, 1);
    compare_strobes("rd");

    // Reset while the address ACK is being driven, SCL high
    mon_en = 1'b0;
    dbyte = 8'h84;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(dbyte[i], 0, r);
    #(Q) sda_ctl = 1'b1;
    #(Q) scl_ctl = 1'b1;
    #(Q / 2);
    check("rst_ack_driven", sda_oe, 1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {reg_wr_en, start_pulse, stop_pulse}, 0);
    #(Q) scl_ctl = 1'b0;
    #(Q) sys_rst_n = 1'b1;
    #(Q);
    ptr_m = 8'h00;
    obs_q.delete();
    exp_q.delete();
    oe_prev = sda_oe;
    mon_en = 1'b1;
    start_cnt = 0; stop_cnt = 0;
    do_write(8'h84, 2, {8'h00, 8'h77, 8'h30}, 1'b0, acks);
    i2c_stop();
    model_write(8'h84, 2, {8'h00, 8'h77, 8'h30});
    check("post_rst_acks", acks, 4'b0111);
    check("post_rst_starts", start_cnt, 1);
    check("post_rst_reg_addr", reg_addr, ptr_m);
    compare_strobes("post_rst");

    // Randomised writes and pointer-continuing reads
    for (int t = 0; t < 4; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] p, v;
        p = 8'($urandom_range(0, 255));
        v = 8'($urandom_range(0, 255));
        do_write(8'h84, 2, {8'h00, v, p}, 1'b0, acks);
        i2c_stop();
        model_write(8'h84, 2, {8'h00, v, p});
        check($sformatf("rnd%0d_wr_acks", t), acks, 4'b0111);
      end else begin
        i2c_start();
        write_byte(8'h85, 0, a);
        check($sformatf("rnd%0d_rd_ack", t), a, 1);
        for (int k = 0; k < 2; k++) begin
          read_byte(k == 1, rb);
          model_read(ev);
          check($sformatf("rnd%0d_rd_byte%0d", t, k), rb, ev);
        end
        i2c_stop();
      end
      check($sformatf("rnd%0d_reg_addr", t), reg_addr, ptr_m);
      compare_strobes($sformatf("rnd%0d", t));
    end

    check("oe_stable_while_scl_high", oe_viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
